detect_sched: RTL and testbench
===============================

DETECT_SCHED -- requirements
Module: detect_sched

Interface
REQ-001 Parameter: CNT_W, default 8, width of each per-requester match counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0/req1  input  1 each  requester i asks for the shared detector.
REQ-005 vld0/vld1  input  1 each  sym_i valid this cycle.
REQ-006 sym0/sym1  input  2 each  2-bit symbol from requester i.
REQ-007 last0/last1  input  1 each  accepted symbol is the final one of requester i's frame.
REQ-008 gnt0/gnt1  output  1 each  registered grant; at most one high in any cycle.
REQ-009 hit  output  1  one-cycle pulse: shared detector reached MATCH.
REQ-010 hit_id  output  1  owner of the symbol that caused hit; 0 when hit low.
REQ-011 cnt0/cnt1  output  CNT_W each  saturating match count per requester.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 Scheduler FSM states shall be IDLE, OWN0, OWN1 and FLUSH; gnt_i is high only in OWN_i.
REQ-014 IDLE: with exactly one req_i high, the next state shall be OWN_i; with neither high, the FSM shall stay in IDLE.
REQ-015 IDLE with both req high: the grant shall go to the requester not served last (round-robin pointer); after reset the pointer shall favour requester 0.
REQ-016 Grant latency: req_i high in IDLE at cycle t shall give gnt_i high at t+1.
REQ-017 A symbol is accepted only when gnt_i and vld_i are both high; the other requester's inputs shall be ignored.
REQ-018 OWN_i shall hold until an accepted symbol carries last_i=1; dropping req_i mid-frame shall not release the grant.
REQ-019 An accepted last symbol shall move the FSM to FLUSH for exactly one cycle, update the pointer to i, and then return to IDLE.
REQ-020 Shared detector states: S0, S1, S2 and MATCH; it advances only on accepted symbols and otherwise holds.
REQ-021 S0: on 01 go to S1; on any other symbol stay in S0.
REQ-022 S1: on 10 go to S2; on 01 stay in S1; on 00 or 11 go to S0.
REQ-023 S2: on 11 go to MATCH; on 01 go to S1; on 00 or 10 go to S0.
REQ-024 MATCH: on 01 go to S1; on any other symbol go to S0.
REQ-025 hit shall be high during the cycle after the accepted symbol that entered MATCH (Moore output); hit_id shall equal that symbol's owner.
REQ-026 cnt_i shall increment at the same edge the detector enters MATCH, so it is visible in the hit cycle; at 2^CNT_W-1 it shall saturate, with no wrap.
REQ-027 The detector shall be forced to S0 at the end of the FLUSH cycle; a match completed by a last symbol shall still report hit during FLUSH.
REQ-028 Detector state shall never carry across ownership: a sequence split across two frames shall not match.
REQ-029 A request arriving during OWN or FLUSH shall wait; arbitration occurs only in IDLE.

Reset
REQ-030 rst_n=0 at a rising edge shall set FSM=IDLE, detector=S0, pointer=1 (favours requester 0), and gnt0, gnt1, hit, hit_id, busy to 0, and cnt0, cnt1 to 0.
REQ-031 Reset asserted mid-frame shall abort the frame; the frame shall not be resumed.

Structure
REQ-032 A shared package shall hold the scheduler state encodings (IDLE/OWN0/OWN1/FLUSH), the detector state encodings (S0/S1/S2/MATCH) and the 2-bit symbol constants.
REQ-033 The detector shall be one sub-module, sym_detector, with inputs clk, rst_n, clr, adv and sym[1:0], and output match.

Verification
REQ-034 Reset, then req0=1 with symbols 01,10,11(last) accepted on consecutive cycles -> gnt0 one cycle after req; hit=1, hit_id=0, cnt0=1 in the FLUSH cycle.
REQ-035 req0 and req1 both asserted in the same IDLE cycle after reset -> gnt0 first; after req0's last, FLUSH, then gnt1; a repeat tie -> gnt0 again.
REQ-036 Requester 0 sends 01,10(last), then requester 1 sends 11(last) -> no hit; cnt0=cnt1=0.
REQ-037 While owned by requester 1, vld0=1 with sym0=01,10,11 -> no detector change; gnt0 stays 0.
REQ-038 Requester 1 sends 255 matches, then 1 more, with CNT_W=8 -> cnt1=255 and hit still pulses for the extra match.
REQ-039 rst_n=0 after 01,10 in OWN0 -> all outputs 0 next cycle; a subsequent 11 from requester 0 after re-grant gives no hit.

Source files
------------

// File: rtl/detect_sched_pkg.sv
// Shared encodings for the detect_sched scheduler and its pattern detector.
// Holds no logic; latency and backpressure do not apply.
package detect_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_FLUSH = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    DET_S0    = 2'd0,
    DET_S1    = 2'd1,
    DET_S2    = 2'd2,
    DET_MATCH = 2'd3
  } det_state_t;

  localparam logic [1:0] SYM_00 = 2'b00;
  localparam logic [1:0] SYM_01 = 2'b01;
  localparam logic [1:0] SYM_10 = 2'b10;
  localparam logic [1:0] SYM_11 = 2'b11;

endpackage

// File: rtl/detect_sched_if.sv
// Requester-facing bus of detect_sched: requests/symbols in, grants/hit/counts out.
// Grants are registered; the requester holds vld/sym until granted.
interface detect_sched_if #(
  parameter int CNT_W = 8
);

  logic             req0;
  logic             req1;
  logic             vld0;
  logic             vld1;
  logic [1:0]       sym0;
  logic [1:0]       sym1;
  logic             last0;
  logic             last1;
  logic             gnt0;
  logic             gnt1;
  logic             hit;
  logic             hit_id;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             busy;

  modport master (
    output req0, req1, vld0, vld1, sym0, sym1, last0, last1,
    input  gnt0, gnt1, hit, hit_id, cnt0, cnt1, busy
  );

  modport slave (
    input  req0, req1, vld0, vld1, sym0, sym1, last0, last1,
    output gnt0, gnt1, hit, hit_id, cnt0, cnt1, busy
  );

endinterface

// File: rtl/detect_sched_sym_detector.sv
// Moore detector for the symbol sequence 01,10,11; advances only when adv is high.
// match is visible the cycle after the completing symbol; no backpressure, clr wins over adv.
module sym_detector
  import detect_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  input  logic [1:0] sym,
  output logic       match
);

  det_state_t state_q;
  det_state_t state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DET_S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = DET_S0;
    end else if (adv) begin
      case (state_q)
        DET_S0: begin
          if (sym == SYM_01) state_d = DET_S1;
          else               state_d = DET_S0;
        end
        DET_S1: begin
          if (sym == SYM_10)      state_d = DET_S2;
          else if (sym == SYM_01) state_d = DET_S1;
          else                    state_d = DET_S0;
        end
        DET_S2: begin
          if (sym == SYM_11)      state_d = DET_MATCH;
          else if (sym == SYM_01) state_d = DET_S1;
          else                    state_d = DET_S0;
        end
        DET_MATCH: begin
          if (sym == SYM_01) state_d = DET_S1;
          else               state_d = DET_S0;
        end
        default: state_d = DET_S0;
      endcase
    end
  end

  assign match = (state_q == DET_MATCH);

endmodule

// File: rtl/detect_sched.sv
// Round-robin owner of one shared sequence detector for two framed requesters.
// Grant one cycle after request in IDLE, hit one cycle after the completing symbol; losers wait for IDLE.
module detect_sched
  import detect_sched_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  detect_sched_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sched_state_t     state_q;
  sched_state_t     state_d;
  logic             ptr_q;
  logic             ptr_d;
  logic             adv_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;
  logic [CNT_W-1:0] cnt0_d;
  logic [CNT_W-1:0] cnt1_d;
  logic             acc0;
  logic             acc1;
  logic             adv;
  logic [1:0]       sym_sel;
  logic             det_clr;
  logic             det_match;
  logic             hit_w;

  // ptr_q names the requester served last, so a tie goes to the other one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b1;
      adv_q   <= 1'b0;
      owner_q <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      adv_q   <= adv;
      owner_q <= acc1;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req0 && bus.req1) state_d = ptr_q ? ST_OWN0 : ST_OWN1;
        else if (bus.req0)        state_d = ST_OWN0;
        else if (bus.req1)        state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (bus.vld0 && bus.last0) begin
          state_d = ST_FLUSH;
          ptr_d   = 1'b0;
        end
      end
      ST_OWN1: begin
        if (bus.vld1 && bus.last1) begin
          state_d = ST_FLUSH;
          ptr_d   = 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign acc0    = (state_q == ST_OWN0) && bus.vld0;
  assign acc1    = (state_q == ST_OWN1) && bus.vld1;
  assign adv     = acc0 || acc1;
  assign sym_sel = acc1 ? bus.sym1 : bus.sym0;
  assign det_clr = (state_q == ST_FLUSH);

  sym_detector u_det (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (det_clr),
    .adv   (adv),
    .sym   (sym_sel),
    .match (det_match)
  );

  // MATCH is only entered on an accepted symbol, so adv_q marks a fresh entry
  assign hit_w = det_match && adv_q;

  // Count shown during the hit cycle already includes that hit; it is committed at the next edge
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (hit_w && !owner_q && (cnt0_q != CNT_MAX)) cnt0_d = cnt0_q + CNT_W'(1);
    if (hit_w &&  owner_q && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + CNT_W'(1);
  end

  assign bus.gnt0   = (state_q == ST_OWN0);
  assign bus.gnt1   = (state_q == ST_OWN1);
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.hit    = hit_w;
  assign bus.hit_id = hit_w && owner_q;
  assign bus.cnt0   = cnt0_d;
  assign bus.cnt1   = cnt1_d;

endmodule

// File: tb/tb_detect_sched.sv
// Directed bench for detect_sched: reset, grant latency, round-robin, isolation, saturation, abort.
module tb_detect_sched;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  detect_sched_if #(.CNT_W(8)) bus ();

  detect_sched #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.vld0 = 0; bus.vld1 = 0;
    bus.sym0 = 2'b00; bus.sym1 = 2'b00; bus.last0 = 0; bus.last1 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    cycle();
    cycle();
    rst_n = 1;
  endtask

  task automatic send0(input logic [1:0] s, input logic l);
    bus.vld0 = 1; bus.sym0 = s; bus.last0 = l;
    cycle();
    bus.vld0 = 0; bus.last0 = 0;
  endtask

  task automatic send1(input logic [1:0] s, input logic l);
    bus.vld1 = 1; bus.sym1 = s; bus.last1 = l;
    cycle();
    bus.vld1 = 0; bus.last1 = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".gnt0"},   bus.gnt0,   0);
    check({tag, ".gnt1"},   bus.gnt1,   0);
    check({tag, ".hit"},    bus.hit,    0);
    check({tag, ".hit_id"}, bus.hit_id, 0);
    check({tag, ".busy"},   bus.busy,   0);
    check({tag, ".cnt0"},   bus.cnt0,   0);
    check({tag, ".cnt1"},   bus.cnt1,   0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 0;
    idle_inputs();

    // reset state
    do_reset();
    check_all_zero("reset");

    // single match by requester 0, completed by the last symbol
    bus.req0 = 1;
    cycle();
    check("t1.gnt0", bus.gnt0, 1);
    check("t1.gnt1", bus.gnt1, 0);
    check("t1.busy", bus.busy, 1);
    send0(2'b01, 0);
    check("t1.hit_s1", bus.hit, 0);
    send0(2'b10, 0);
    check("t1.hit_s2", bus.hit, 0);
    bus.req0 = 0;
    send0(2'b11, 1);
    check("t1.flush_gnt0", bus.gnt0, 0);
    check("t1.flush_busy", bus.busy, 1);
    check("t1.hit", bus.hit, 1);
    check("t1.hit_id", bus.hit_id, 0);
    check("t1.cnt0", bus.cnt0, 1);
    check("t1.cnt1", bus.cnt1, 0);
    cycle();
    check("t1.idle_hit", bus.hit, 0);
    check("t1.idle_busy", bus.busy, 0);
    check("t1.idle_cnt0", bus.cnt0, 1);

    // round-robin on ties, waiting through FLUSH
    do_reset();
    bus.req0 = 1; bus.req1 = 1;
    cycle();
    check("t2.tie1_gnt0", bus.gnt0, 1);
    check("t2.tie1_gnt1", bus.gnt1, 0);
    send0(2'b00, 1);
    check("t2.flush_gnt0", bus.gnt0, 0);
    check("t2.flush_gnt1", bus.gnt1, 0);
    cycle();
    check("t2.idle_busy", bus.busy, 0);
    check("t2.idle_gnt1", bus.gnt1, 0);
    cycle();
    check("t2.tie2_gnt1", bus.gnt1, 1);
    check("t2.tie2_gnt0", bus.gnt0, 0);
    bus.req1 = 0;
    cycle();
    check("t2.hold_gnt1", bus.gnt1, 1);
    send1(2'b00, 1);
    check("t2.flush2_gnt1", bus.gnt1, 0);
    bus.req1 = 1;
    cycle();
    cycle();
    check("t2.tie3_gnt0", bus.gnt0, 1);
    check("t2.tie3_gnt1", bus.gnt1, 0);
    bus.req0 = 0; bus.req1 = 0;
    send0(2'b00, 1);
    cycle();

    // a sequence split across frames must not match
    bus.req0 = 1;
    cycle();
    check("t3.gnt0", bus.gnt0, 1);
    send0(2'b01, 0);
    bus.req0 = 0;
    send0(2'b10, 1);
    check("t3.flush_hit", bus.hit, 0);
    bus.req1 = 1;
    cycle();
    cycle();
    check("t3.gnt1", bus.gnt1, 1);
    bus.req1 = 0;
    send1(2'b11, 1);
    check("t3.hit", bus.hit, 0);
    check("t3.cnt0", bus.cnt0, 0);
    check("t3.cnt1", bus.cnt1, 0);
    cycle();

    // requester 0 inputs ignored while requester 1 owns the detector
    bus.req1 = 1;
    cycle();
    check("t4.gnt1", bus.gnt1, 1);
    send0(2'b01, 0);
    check("t4.a_gnt0", bus.gnt0, 0);
    send0(2'b10, 0);
    check("t4.b_gnt0", bus.gnt0, 0);
    send0(2'b11, 0);
    check("t4.c_gnt0", bus.gnt0, 0);
    check("t4.c_hit", bus.hit, 0);
    send1(2'b11, 0);
    check("t4.r1_hit", bus.hit, 0);
    check("t4.cnt0", bus.cnt0, 0);

    // 256 matches by requester 1: count saturates, hit keeps pulsing
    for (int i = 1; i <= 256; i++) begin
      send1(2'b01, 0);
      send1(2'b10, 0);
      send1(2'b11, 0);
      check("t5.hit", bus.hit, 1);
      check("t5.hit_id", bus.hit_id, 1);
      check("t5.cnt1", bus.cnt1, (i > 255) ? 255 : i);
    end
    cycle();
    check("t5.pulse_hit", bus.hit, 0);
    check("t5.pulse_cnt1", bus.cnt1, 255);
    check("t5.cnt0", bus.cnt0, 0);
    bus.req1 = 0;
    send1(2'b00, 1);
    check("t5.flush_hit", bus.hit, 0);
    cycle();

    // reset mid-frame aborts the frame
    do_reset();
    bus.req0 = 1;
    cycle();
    check("t6.gnt0", bus.gnt0, 1);
    send0(2'b01, 0);
    send0(2'b10, 0);
    rst_n = 0;
    cycle();
    check_all_zero("t6.rst");
    rst_n = 1;
    cycle();
    check("t6.regnt0", bus.gnt0, 1);
    bus.req0 = 0;
    send0(2'b11, 1);
    check("t6.hit", bus.hit, 0);
    check("t6.cnt0", bus.cnt0, 0);
    cycle();
    check("t6.idle_busy", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
